// File: rtl/am_mux_seq.sv
// Registered inverting N-channel mux with channel tag and optional auto-scan.
// Define AM_MUX_SEQ_SCAN_EN to build the scan counter and wrap pulse.
module am_mux_seq #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned SELW     = 1
) (
    input  logic                      clk,
    input  logic                      rst_,
    input  logic [CHANNELS*WIDTH-1:0] d,
    input  logic [SELW-1:0]           sel,
    input  logic                      mode,
    input  logic                      g_,
    output logic [WIDTH-1:0]          y,
    output logic                      vld,
    output logic [SELW-1:0]           ch,
    output logic                      wrap
);

    logic [WIDTH-1:0] y_d, y_q;
    logic             vld_d, vld_q;
    logic [SELW-1:0]  ch_d, ch_q;
    logic [SELW-1:0]  mux_idx;
    logic [WIDTH-1:0] mux_word;
    logic             scan_mode;
    logic             sel_ok;

`ifdef AM_MUX_SEQ_SCAN_EN
    localparam logic [SELW-1:0] LAST = SELW'(CHANNELS - 1);

    logic [SELW-1:0] cnt_d, cnt_q;
    logic            wrap_d, wrap_q;

    assign scan_mode = mode;
    assign mux_idx   = scan_mode ? cnt_q : sel;
`else
    logic unused_mode;

    assign unused_mode = mode;
    assign scan_mode   = 1'b0;
    assign mux_idx     = sel;
`endif

    assign sel_ok = (32'(sel) < CHANNELS);

    always_comb begin
        mux_word = '1;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (32'(mux_idx) == k) begin
                mux_word = d[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        y_d   = '1;
        vld_d = 1'b0;
        ch_d  = ch_q;
`ifdef AM_MUX_SEQ_SCAN_EN
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
`endif
        if (!g_) begin
            if (scan_mode) begin
`ifdef AM_MUX_SEQ_SCAN_EN
                y_d    = ~mux_word;
                vld_d  = 1'b1;
                ch_d   = cnt_q;
                wrap_d = (cnt_q == LAST);
                cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
`endif
            end else begin
                // Direct capture always rewinds the scan so the next scan starts at channel 0.
                ch_d = sel;
                if (sel_ok) begin
                    y_d   = ~mux_word;
                    vld_d = 1'b1;
                end
`ifdef AM_MUX_SEQ_SCAN_EN
                cnt_d = '0;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            y_q   <= '1;
            vld_q <= 1'b0;
            ch_q  <= '0;
        end else begin
            y_q   <= y_d;
            vld_q <= vld_d;
            ch_q  <= ch_d;
        end
    end

`ifdef AM_MUX_SEQ_SCAN_EN
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign wrap = wrap_q;
`else
    assign wrap = 1'b0;
`endif

    assign y   = y_q;
    assign vld = vld_q;
    assign ch  = ch_q;

endmodule
